// File: rtl/sif_pkg.sv
// Shared types and widths for the X-side bus arbiter.
package sif_pkg;

    localparam int SIF_AW = 16;
    localparam int SIF_DW = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2
    } sif_state_e;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } sif_kind_e;

endpackage

// File: rtl/sif_rr_picker.sv
// Combinational round-robin picker: scans from ptr+1 upward (mod NREQ)
// and returns the first valid requester as a one-hot grant plus its index.
module sif_rr_picker #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_any
);

    int          cand;
    logic [IW-1:0] cand_idx;

    // Modulo scan; the wrap from NREQ-1 back to 0 falls out of the modulo.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand     = (int'(ptr) + k) % NREQ;
            cand_idx = IW'(cand);
            if (!grant_any && req_valid[cand_idx]) begin
                grant_any       = 1'b1;
                grant_idx       = cand_idx;
                grant[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sif_arbiter.sv
// Round-robin arbiter sharing one X-side bus between NREQ requesters.
// Every output is a flop; the X-side read data is captured RD_LAT cycles
// after the read-strobe cycle.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a request; accepts one and pulses req_ready
// ISSUE   | request latched; next edge raises exactly one strobe
// RD_WAIT | strobe issued, down-counting until the read data capture
module sif_arbiter
    import sif_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_wr,
    input  logic [NREQ*SIF_AW-1:0] req_addr,
    input  logic [NREQ*SIF_DW-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [SIF_DW-1:0]      rsp_data,
    output logic [SIF_AW-1:0]      xa_addr,
    output logic [SIF_DW-1:0]      xa_data_wr,
    output logic                   xa_wr_s,
    output logic                   xa_rd_s,
    input  logic [SIF_DW-1:0]      xa_data_rd,
    output logic                   busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = 3;

    sif_state_e        state_q, state_d;
    sif_kind_e         kind_q, kind_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     lat_q, lat_d;
    logic              rsp_pend_q, rsp_pend_d;
    logic [IW-1:0]     rsp_idx_q, rsp_idx_d;

    logic [NREQ-1:0]   rdy_d;
    logic [NREQ-1:0]   rsp_valid_d;
    logic [SIF_DW-1:0] rsp_data_d;
    logic [SIF_AW-1:0] addr_d;
    logic [SIF_DW-1:0] wdata_d;
    logic              wr_s_d, rd_s_d;

    logic [NREQ-1:0]   grant;
    logic [IW-1:0]     grant_idx;
    logic              grant_any;

    logic [SIF_AW-1:0] addr_arr  [NREQ];
    logic [SIF_DW-1:0] wdata_arr [NREQ];

    // Unpack the flat per-requester address/data buses.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i]  = req_addr[SIF_AW*i +: SIF_AW];
            wdata_arr[i] = req_data[SIF_DW*i +: SIF_DW];
        end
    end

    sif_rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Next-state and next-output decode. The read capture runs one cycle
    // behind RD_WAIT so the FSM is back in IDLE while the data lands,
    // giving a 2+RD_LAT cycle read turnaround.
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        lat_d       = lat_q;
        rsp_pend_d  = 1'b0;
        rsp_idx_d   = rsp_idx_q;
        rdy_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data;
        addr_d      = xa_addr;
        wdata_d     = xa_data_wr;
        wr_s_d      = 1'b0;
        rd_s_d      = 1'b0;

        if (rsp_pend_q) begin
            rsp_valid_d[rsp_idx_q] = 1'b1;
            rsp_data_d             = xa_data_rd;
        end

        unique case (state_q)
            IDLE: begin
                if (grant_any) begin
                    rdy_d   = grant;
                    idx_d   = grant_idx;
                    ptr_d   = grant_idx;
                    kind_d  = req_wr[grant_idx] ? WR : RD;
                    addr_d  = addr_arr[grant_idx];
                    wdata_d = wdata_arr[grant_idx];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (kind_q == WR) begin
                    wr_s_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    rd_s_d  = 1'b1;
                    lat_d   = CW'(RD_LAT - 1);
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (lat_q == '0) begin
                    rsp_pend_d = 1'b1;
                    rsp_idx_d  = idx_q;
                    state_d    = IDLE;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            kind_q     <= RD;
            ptr_q      <= IW'(NREQ - 1);
            idx_q      <= '0;
            lat_q      <= '0;
            rsp_pend_q <= 1'b0;
            rsp_idx_q  <= '0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            xa_addr    <= '0;
            xa_data_wr <= '0;
            xa_wr_s    <= 1'b0;
            xa_rd_s    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            lat_q      <= lat_d;
            rsp_pend_q <= rsp_pend_d;
            rsp_idx_q  <= rsp_idx_d;
            req_ready  <= rdy_d;
            rsp_valid  <= rsp_valid_d;
            rsp_data   <= rsp_data_d;
            xa_addr    <= addr_d;
            xa_data_wr <= wdata_d;
            xa_wr_s    <= wr_s_d;
            xa_rd_s    <= rd_s_d;
            busy       <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_sif_arbiter.sv
// Scoreboard bench for sif_arbiter: stimulus pushes expected grants, bus
// strobes and read responses; a negedge monitor pops and compares them.
module tb_sif_arbiter;

    localparam int NREQ   = 4;
    localparam int RD_LAT = 2;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } item_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_exp_t;

    typedef struct {
        int          idx;
        logic [15:0] data;
    } rsp_exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid, req_wr;
    logic [NREQ*16-1:0]   req_addr, req_data;
    logic [NREQ-1:0]      req_ready, rsp_valid;
    logic [15:0]          rsp_data, xa_addr, xa_data_wr, xa_data_rd;
    logic                 xa_wr_s, xa_rd_s, busy;

    logic                 drv_vld  [NREQ];
    logic                 drv_wr   [NREQ];
    logic [15:0]          drv_addr [NREQ];
    logic [15:0]          drv_data [NREQ];
    logic                 man_vld  [NREQ];
    logic                 man_wr;
    logic [15:0]          man_addr, man_data;

    item_t                pend [NREQ][$];
    int                   exp_grant [$];
    wr_exp_t              exp_wr [$];
    logic [15:0]          exp_rd [$];
    rsp_exp_t             exp_rsp [$];
    int                   grant_cyc [$];
    int                   wr_cyc [$];
    int                   rd_cyc [$];
    int                   rsp_cyc [$];

    int                   tests = 0;
    int                   fails = 0;
    int                   cyc = 0;
    int                   rd_due = -1;
    logic [15:0]          rd_val = '0;

    sif_arbiter #(
        .NREQ   (NREQ),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .xa_addr    (xa_addr),
        .xa_data_wr (xa_data_wr),
        .xa_wr_s    (xa_wr_s),
        .xa_rd_s    (xa_rd_s),
        .xa_data_rd (xa_data_rd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Requester ports: queued driver traffic, with a manual override lane.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]          = drv_vld[i] | man_vld[i];
            req_wr[i]             = man_vld[i] ? man_wr : drv_wr[i];
            req_addr[16*i +: 16]  = man_vld[i] ? man_addr : drv_addr[i];
            req_data[16*i +: 16]  = man_vld[i] ? man_data : drv_data[i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit pend_empty();
        for (int i = 0; i < NREQ; i++)
            if (pend[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic add_wr(input int i, input logic [15:0] a, input logic [15:0] d);
        item_t   it;
        wr_exp_t w;
        it.wr = 1'b1; it.addr = a; it.data = d;
        w.addr = a; w.data = d;
        pend[i].push_back(it);
        exp_wr.push_back(w);
    endtask

    task automatic add_rd(input int i, input logic [15:0] a, input bit has_rsp,
                          input logic [15:0] rsp);
        item_t    it;
        rsp_exp_t r;
        it.wr = 1'b0; it.addr = a; it.data = 16'h0000;
        pend[i].push_back(it);
        exp_rd.push_back(a);
        if (has_rsp) begin
            r.idx = i; r.data = rsp;
            exp_rsp.push_back(r);
        end
    endtask

    task automatic wait_idle(input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < budget) begin
            @(posedge clk); #3;
            n++;
            if (pend_empty() && !busy && exp_grant.size() == 0 && exp_wr.size() == 0 &&
                exp_rd.size() == 0 && exp_rsp.size() == 0)
                quiet++;
            else
                quiet = 0;
        end
        check("idle_reached", 64'(quiet >= 3), 64'd1);
    endtask

    task automatic clear_logs();
        grant_cyc.delete(); wr_cyc.delete(); rd_cyc.delete(); rsp_cyc.delete();
    endtask

    // Background requester driver: retire accepted items, present the next.
    initial begin
        for (int i = 0; i < NREQ; i++) begin
            drv_vld[i] = 1'b0; drv_wr[i] = 1'b0; drv_addr[i] = '0; drv_data[i] = '0;
        end
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (rst_n && req_ready[i] && pend[i].size() > 0)
                    void'(pend[i].pop_front());
                if (pend[i].size() > 0) begin
                    drv_vld[i]  = 1'b1;
                    drv_wr[i]   = pend[i][0].wr;
                    drv_addr[i] = pend[i][0].addr;
                    drv_data[i] = pend[i][0].data;
                end else begin
                    drv_vld[i] = 1'b0;
                end
            end
        end
    end

    // X-side read slave: data is valid only in the cycle RD_LAT after the strobe.
    initial begin
        xa_data_rd = 16'hDEAD;
        forever begin
            @(posedge clk); #1;
            xa_data_rd = (cyc == rd_due) ? rd_val : 16'hDEAD;
        end
    end

    // Monitor: compare every DUT output event against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (|req_ready) begin
                check("ready_onehot", 64'($onehot(req_ready)), 64'd1);
                check("busy_in_issue", 64'(busy), 64'd1);
                if (exp_grant.size() == 0)
                    check("unexpected_grant", 64'(req_ready), 64'd0);
                else
                    check("grant", 64'(req_ready), 64'd1 << exp_grant.pop_front());
                grant_cyc.push_back(cyc);
            end
            if (xa_wr_s) begin
                if (exp_wr.size() == 0)
                    check("unexpected_wr_s", 64'(xa_addr), 64'hFFFF_FFFF);
                else begin
                    wr_exp_t w;
                    w = exp_wr.pop_front();
                    check("wr_addr", 64'(xa_addr), 64'(w.addr));
                    check("wr_data", 64'(xa_data_wr), 64'(w.data));
                end
                wr_cyc.push_back(cyc);
            end
            if (xa_rd_s) begin
                if (exp_rd.size() == 0)
                    check("unexpected_rd_s", 64'(xa_addr), 64'hFFFF_FFFF);
                else
                    check("rd_addr", 64'(xa_addr), 64'(exp_rd.pop_front()));
                rd_due = cyc + RD_LAT;
                rd_val = xa_addr + 16'h1134;
                rd_cyc.push_back(cyc);
            end
            if (|rsp_valid) begin
                check("rsp_onehot", 64'($onehot(rsp_valid)), 64'd1);
                if (exp_rsp.size() == 0)
                    check("unexpected_rsp", 64'(rsp_valid), 64'd0);
                else begin
                    rsp_exp_t r;
                    r = exp_rsp.pop_front();
                    check("rsp_valid", 64'(rsp_valid), 64'd1 << r.idx);
                    check("rsp_data", 64'(rsp_data), 64'(r.data));
                end
                rsp_cyc.push_back(cyc);
            end
        end
    end

    a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n) !(xa_wr_s && xa_rd_s))
        else begin
            fails++;
            $display("FAIL strobe_excl: wr_s=%0b rd_s=%0b, expected never both high", xa_wr_s, xa_rd_s);
        end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int rel_cyc;
        bit found;
        rst_n    = 1'b0;
        man_wr   = 1'b0;
        man_addr = '0;
        man_data = '0;
        for (int i = 0; i < NREQ; i++) man_vld[i] = 1'b0;

        repeat (2) @(posedge clk); #3;
        check("reset_outputs", 64'({req_ready, rsp_valid, rsp_data, xa_addr, xa_data_wr,
                                    xa_wr_s, xa_rd_s, busy}), 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;

        // Single write from requester 0.
        clear_logs();
        exp_grant.push_back(0);
        add_wr(0, 16'h0010, 16'hBEEF);
        wait_idle(50);
        check("A_wr_count", 64'(wr_cyc.size()), 64'd1);
        check("A_strobe_after_ready", 64'(wr_cyc[0] - grant_cyc[0]), 64'd1);

        // Single read from requester 2, response RD_LAT+1 after the strobe.
        clear_logs();
        exp_grant.push_back(2);
        add_rd(2, 16'h0100, 1'b1, 16'h1234);
        wait_idle(50);
        check("B_rsp_count", 64'(rsp_cyc.size()), 64'd1);
        check("B_rd_after_ready", 64'(rd_cyc[0] - grant_cyc[0]), 64'd1);
        check("B_rsp_latency", 64'(rsp_cyc[0] - rd_cyc[0]), 64'(RD_LAT + 1));

        // All four requesters hold writes from reset: 0,1,2,3,0 every 2 cycles.
        @(posedge clk); #3;
        rst_n = 1'b0;
        clear_logs();
        for (int i = 0; i < NREQ; i++) exp_grant.push_back(i);
        exp_grant.push_back(0);
        add_wr(0, 16'h1000, 16'hA000);
        add_wr(1, 16'h1001, 16'hA001);
        add_wr(2, 16'h1002, 16'hA002);
        add_wr(3, 16'h1003, 16'hA003);
        add_wr(0, 16'h1004, 16'hA004);
        repeat (2) @(posedge clk); #3;
        rst_n   = 1'b1;
        rel_cyc = cyc;
        wait_idle(100);
        check("C_grant_count", 64'(grant_cyc.size()), 64'd5);
        check("C_first_accept", 64'(grant_cyc[0] - rel_cyc), 64'd1);
        for (int k = 1; k < 5; k++)
            check("C_grant_spacing", 64'(grant_cyc[k] - grant_cyc[k-1]), 64'd2);

        // ptr=3 with requesters 1 and 3 valid: 1 (via wrap) first, then 3.
        exp_grant.push_back(3);
        add_wr(3, 16'h0300, 16'h3333);
        wait_idle(50);
        clear_logs();
        exp_grant.push_back(1);
        exp_grant.push_back(3);
        add_rd(1, 16'h0200, 1'b1, 16'h1334);
        add_wr(3, 16'h0304, 16'h4444);
        wait_idle(100);
        check("D_read_spacing", 64'(grant_cyc[1] - grant_cyc[0]), 64'(2 + RD_LAT));

        // Reset during RD_WAIT aborts the read; traffic resumes cleanly.
        exp_grant.push_back(1);
        pend[1].push_back('{1'b0, 16'h0300, 16'h0000});
        exp_rd.push_back(16'h0300);
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(posedge clk); #3;
            if (xa_rd_s) found = 1'b1;
        end
        check("E_rd_seen", 64'(found), 64'd1);
        @(posedge clk); #3;
        check("E_busy_rd_wait", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("E_reset_outputs", 64'({req_ready, rsp_valid, rsp_data, xa_addr, xa_data_wr,
                                      xa_wr_s, xa_rd_s, busy}), 64'd0);
        repeat (3) @(posedge clk); #3;
        rst_n = 1'b1;
        exp_grant.push_back(0);
        exp_grant.push_back(2);
        add_rd(0, 16'h0040, 1'b1, 16'h1174);
        add_wr(2, 16'h0050, 16'h5555);
        wait_idle(100);

        // Request raised in ISSUE and dropped in RD_WAIT is never granted.
        exp_grant.push_back(0);
        add_rd(0, 16'h0080, 1'b1, 16'h11B4);
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(posedge clk); #3;
            if (req_ready[0]) found = 1'b1;
        end
        check("F_ready_seen", 64'(found), 64'd1);
        man_wr     = 1'b1;
        man_addr   = 16'h0999;
        man_data   = 16'h9999;
        man_vld[2] = 1'b1;
        @(posedge clk); #3;
        @(posedge clk); #3;
        man_vld[2] = 1'b0;
        exp_grant.push_back(3);
        add_wr(3, 16'h0070, 16'h7777);
        wait_idle(100);

        check("end_grants_left", 64'(exp_grant.size()), 64'd0);
        check("end_rsp_left", 64'(exp_rsp.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
